// File: rtl/chronometer_pkg.sv
// Shared definitions for the chronometer display slice.
//   - nibble / segment widths
//   - converter FSM state encoding
//   - seven-segment decoder (active-high, {g,f,e,d,c,b,a}); non-decimal nibbles blank
package chronometer_pkg;

  localparam int NIBBLE_W = 4;
  localparam int SEG_W    = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } convState_t;

  function automatic logic [SEG_W-1:0] sevenSegDecode(input logic [NIBBLE_W-1:0] nibble);
    case (nibble)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high reset (aborts a conversion in flight)
//   start  in   sampled in IDLE; 1 captures bin and begins a conversion
//   bin    in   WIDTH-bit binary value
//   busy   out  1 while a conversion is in SHIFT or DONE
//   done   out  one-cycle pulse, bcd updated in the same cycle
//   bcd    out  DIGITS packed BCD nibbles, digit0 = bcd[3:0]; only written in DONE
module bin2bcd_seq
  import chronometer_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WIDTH-1:0]           bin,
  output logic                       busy,
  output logic                       done,
  output logic [NIBBLE_W*DIGITS-1:0] bcd
);

  localparam int BCD_W = NIBBLE_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  convState_t         state;
  logic [WIDTH-1:0]   shiftReg;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   adjusted;
  logic [CNT_W-1:0]   bitCount;

  // Add-3 correction on every nibble that would overflow past 9 after doubling.
  always_comb begin
    // NOTE: always_comb outputs get a full default first so no path leaves them unassigned (no latch).
    adjusted = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[i*NIBBLE_W +: NIBBLE_W] >= 4'd5)
        adjusted[i*NIBBLE_W +: NIBBLE_W] = scratch[i*NIBBLE_W +: NIBBLE_W] + 4'd3;
    end
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bcd   <= '0;
      done  <= 1'b0;
      // NOTE: shiftReg/scratch/bitCount are deliberately left out of reset; they are
      // always reloaded in IDLE before use, so resetting them buys nothing.
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shiftReg <= bin;
            scratch  <= '0;
            bitCount <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          scratch  <= {adjusted[BCD_W-2:0], shiftReg[WIDTH-1]};
          shiftReg <= shiftReg << 1;
          bitCount <= bitCount + CNT_W'(1);
          if (bitCount == CNT_W'(WIDTH - 1))
            state <= DONE;
        end
        DONE: begin
          bcd   <= scratch;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/chronometer_display.sv
// Chronometer display back end: converts the binary recordTimer count to BCD and
// scans the digits onto a multiplexed NUM_DIGITS-digit 7-segment display.
// Ports:
//   clk            in   system clock
//   resetDisplay   in   synchronous, active-high reset
//   recordTimer    in   binary count from the chronometer
//   holdDisplay    in   1: stop sampling recordTimer (lap hold); a running conversion still finishes
//   bcdDigits      out  latched BCD value, digit0 = bits[3:0]
//   conversionDone out  one-cycle pulse when bcdDigits is updated
//   segments       out  {g,f,e,d,c,b,a}, active-low when COMMON_ANODE=1
//   anodes         out  one-hot digit enable, active-low when COMMON_ANODE=1
module chronometer_display
  import chronometer_pkg::*;
#(
  parameter int FREQ_IN             = 12000000,
  parameter int LIMIT_RECORD_TIMER  = 1000,
  parameter int SIZE_RECORD_TIMER   = $clog2(LIMIT_RECORD_TIMER),
  parameter int NUM_DIGITS          = 4,
  parameter int REFRESH_HZ          = 1000,
  parameter int COMMON_ANODE        = 1,
  parameter int BLANK_LEADING_ZEROS = 1
) (
  input  logic                           clk,
  input  logic                           resetDisplay,
  input  logic [SIZE_RECORD_TIMER-1:0]   recordTimer,
  input  logic                           holdDisplay,
  output logic [NIBBLE_W*NUM_DIGITS-1:0] bcdDigits,
  output logic                           conversionDone,
  output logic [SEG_W-1:0]               segments,
  output logic [NUM_DIGITS-1:0]          anodes
);

  localparam int PRESCALE = FREQ_IN / (REFRESH_HZ * NUM_DIGITS);
  localparam int PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // Output polarity helpers; reset shows digit 0 as "0".
  localparam logic [NUM_DIGITS-1:0] ANODE_RESET =
    (COMMON_ANODE != 0) ? ~NUM_DIGITS'(1) : NUM_DIGITS'(1);
  localparam logic [SEG_W-1:0] SEG_RESET =
    (COMMON_ANODE != 0) ? ~sevenSegDecode(4'd0) : sevenSegDecode(4'd0);

  logic                  convBusy;
  logic                  startConv;
  logic [PRE_W-1:0]      prescaler;
  logic [IDX_W-1:0]      scanIndex;
  logic [NIBBLE_W-1:0]   curNibble;
  logic                  curBlank;
  logic                  zeroAbove;
  logic [SEG_W-1:0]      segHigh;
  logic [NUM_DIGITS-1:0] anodeHigh;

  // Free-running conversion: a new sample is requested whenever the converter is idle
  // and the display is not held.
  assign startConv = !holdDisplay && !convBusy;

  bin2bcd_seq #(
    .WIDTH  (SIZE_RECORD_TIMER),
    .DIGITS (NUM_DIGITS)
  ) uConv (
    .clk   (clk),
    .reset (resetDisplay),
    .start (startConv),
    .bin   (recordTimer),
    .busy  (convBusy),
    .done  (conversionDone),
    .bcd   (bcdDigits)
  );

  // Select the scanned digit and decide leading-zero blanking. zeroAbove walks from the
  // top digit down and stays 1 only while every digit from the top to i is zero.
  always_comb begin
    curNibble = '0;
    curBlank  = 1'b0;
    zeroAbove = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zeroAbove = zeroAbove && (bcdDigits[i*NIBBLE_W +: NIBBLE_W] == 4'd0);
      if (scanIndex == IDX_W'(i)) begin
        curNibble = bcdDigits[i*NIBBLE_W +: NIBBLE_W];
        curBlank  = (BLANK_LEADING_ZEROS != 0) && (i != 0) && zeroAbove;
      end
    end
  end

  assign segHigh   = curBlank ? '0 : sevenSegDecode(curNibble);
  assign anodeHigh = NUM_DIGITS'(1) << scanIndex;

  always_ff @(posedge clk) begin
    if (resetDisplay) begin
      prescaler <= '0;
      scanIndex <= '0;
      anodes    <= ANODE_RESET;
      segments  <= SEG_RESET;
    end else begin
      if (prescaler == PRE_W'(PRESCALE - 1)) begin
        prescaler <= '0;
        scanIndex <= (scanIndex == IDX_W'(NUM_DIGITS - 1)) ? '0 : scanIndex + IDX_W'(1);
      end else begin
        prescaler <= prescaler + PRE_W'(1);
      end
      anodes   <= (COMMON_ANODE != 0) ? ~anodeHigh : anodeHigh;
      segments <= (COMMON_ANODE != 0) ? ~segHigh   : segHigh;
    end
  end

endmodule

// File: tb/tb_chronometer_display.sv
// Directed testbench for chronometer_display (FREQ_IN=12000, REFRESH_HZ=1000, 4 digits,
// common anode, leading-zero blanking). Outputs are sampled 1 time unit after each rising edge.
module tb_chronometer_display;

  logic        clk = 1'b0;
  logic        resetDisplay;
  logic        holdDisplay;
  logic [9:0]  recordTimer;
  logic [15:0] bcdDigits;
  logic        conversionDone;
  logic [6:0]  segments;
  logic [3:0]  anodes;

  int total = 0;
  int bad   = 0;
  int cyc;

  // Active-low segment patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [3:0] anodeSeq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  chronometer_display #(
    .FREQ_IN             (12000),
    .LIMIT_RECORD_TIMER  (1000),
    .SIZE_RECORD_TIMER   (10),
    .NUM_DIGITS          (4),
    .REFRESH_HZ          (1000),
    .COMMON_ANODE        (1),
    .BLANK_LEADING_ZEROS (1)
  ) dut (
    .clk            (clk),
    .resetDisplay   (resetDisplay),
    .recordTimer    (recordTimer),
    .holdDisplay    (holdDisplay),
    .bcdDigits      (bcdDigits),
    .conversionDone (conversionDone),
    .segments       (segments),
    .anodes         (anodes)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Waits up to maxCycles rising edges for conversionDone; cycles = edges waited, -1 on timeout.
  task automatic waitDone(input int maxCycles, output int cycles);
    cycles = -1;
    for (int i = 1; i <= maxCycles; i++) begin
      @(posedge clk); #1;
      if (conversionDone === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  // Watches the scan for nCycles while no conversion may complete; segments must match the
  // pattern expected for whichever digit is currently enabled.
  task automatic scanCheck(input string tag, input int nCycles,
                           input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] expSeg;
    logic [3:0] seen;
    seen = 4'h0;
    for (int i = 0; i < nCycles; i++) begin
      @(posedge clk); #1;
      check({tag, "_no_done"}, {31'd0, conversionDone}, 32'd0);
      case (anodes)
        4'b1110: expSeg = s0;
        4'b1101: expSeg = s1;
        4'b1011: expSeg = s2;
        4'b0111: expSeg = s3;
        default: expSeg = 7'bxxxxxxx;
      endcase
      check({tag, "_segments"}, {25'd0, segments}, {25'd0, expSeg});
      seen = seen | ~anodes;
    end
    check({tag, "_all_digits_scanned"}, {28'd0, seen}, 32'h0000000F);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---- reset ----
    resetDisplay = 1'b1;
    holdDisplay  = 1'b1;
    recordTimer  = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bcd",      {16'd0, bcdDigits},      32'h0000);
    check("rst_done",     {31'd0, conversionDone}, 32'd0);
    check("rst_anodes",   {28'd0, anodes},         32'b1110);
    check("rst_segments", {25'd0, segments},       {25'd0, SEG_0});
    resetDisplay = 1'b0;

    // ---- scan: one step every 3 clocks, outputs lag the index by one clock ----
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); #1;
      check("scan_anodes", {28'd0, anodes}, {28'd0, anodeSeq[((k - 1) / 3) % 4]});
      check("scan_segments", {25'd0, segments},
            {25'd0, ((((k - 1) / 3) % 4) == 0) ? SEG_0 : SEG_BLANK});
    end

    // ---- conversion of 999, free-running period of 12 cycles ----
    recordTimer = 10'd999;
    holdDisplay = 1'b0;
    waitDone(20, cyc);
    check("conv999_latency", cyc, 32'd12);
    check("conv999_bcd", {16'd0, bcdDigits}, 32'h0999);
    waitDone(20, cyc);
    check("conv999_period", cyc, 32'd12);
    check("conv999_bcd_again", {16'd0, bcdDigits}, 32'h0999);

    // ---- hold ----
    recordTimer = 10'd123;
    @(posedge clk); #1;
    check("done_pulse_width", {31'd0, conversionDone}, 32'd0);
    waitDone(20, cyc);
    check("conv123_latency", cyc, 32'd11);
    check("conv123_bcd", {16'd0, bcdDigits}, 32'h0123);
    holdDisplay = 1'b1;
    recordTimer = 10'd456;
    scanCheck("hold123", 20, SEG_3, SEG_2, SEG_1, SEG_BLANK);
    check("hold123_bcd", {16'd0, bcdDigits}, 32'h0123);
    holdDisplay = 1'b0;
    waitDone(20, cyc);
    check("release456_latency", cyc, 32'd12);
    check("release456_bcd", {16'd0, bcdDigits}, 32'h0456);

    // ---- hold asserted mid-conversion, input changed during SHIFT ----
    recordTimer = 10'd7;
    repeat (3) @(posedge clk);
    #1;
    holdDisplay = 1'b1;
    recordTimer = 10'd999;
    waitDone(20, cyc);
    check("midhold_latency", cyc, 32'd9);
    check("midhold_bcd", {16'd0, bcdDigits}, 32'h0007);

    // ---- blanking: 0007 shows only digit 0 ----
    scanCheck("blank7", 14, SEG_7, SEG_BLANK, SEG_BLANK, SEG_BLANK);
    check("blank7_bcd", {16'd0, bcdDigits}, 32'h0007);

    // ---- reset after 4 shifts ----
    holdDisplay = 1'b0;
    recordTimer = 10'd999;
    repeat (5) @(posedge clk);
    #1;
    resetDisplay = 1'b1;
    @(posedge clk); #1;
    check("midrst_bcd",      {16'd0, bcdDigits},      32'h0000);
    check("midrst_done",     {31'd0, conversionDone}, 32'd0);
    check("midrst_anodes",   {28'd0, anodes},         32'b1110);
    check("midrst_segments", {25'd0, segments},       {25'd0, SEG_0});
    @(posedge clk); #1;
    check("midrst_done_2", {31'd0, conversionDone}, 32'd0);
    recordTimer  = 10'd5;
    resetDisplay = 1'b0;
    waitDone(20, cyc);
    check("postrst_latency", cyc, 32'd12);
    check("postrst_bcd", {16'd0, bcdDigits}, 32'h0005);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
